// File: rtl/hs32_wbarb_pkg.sv
// Shared types for the hs32 writeback arbiter: the buffered load-return entry.
package hs32_wbarb_pkg;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } hs32_wbent;

  localparam int unsigned NUM_REGS = 16;

endpackage

// File: rtl/hs32_fifo.sv
// Small synchronous FIFO; pointers carry one extra wrap bit so full and empty differ.
module hs32_fifo
  import hs32_wbarb_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter type         T     = hs32_wbent
) (
  input  logic clk,
  input  logic reset,
  input  logic push_i,
  input  T     wdata_i,
  input  logic pop_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  T            mem_q [DEPTH];
  T            mem_d [DEPTH];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_i) begin
      mem_d[wr_ptr_q[AW-1:0]] = wdata_i;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/hs32_wbarb.sv
// Register-file write-port arbiter between the execute stage and buffered load
// returns, with a starvation limit and a per-register outstanding-load scoreboard.
module hs32_wbarb
  import hs32_wbarb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned DEPTH        = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid_i,
  input  logic [3:0]  ex_rd_i,
  input  logic [31:0] ex_data_i,
  input  logic        ex_we1_i,
  input  logic        ex_we2_i,
  output logic        ex_stall_o,
  input  logic        ld_valid_i,
  input  logic [3:0]  ld_rd_i,
  input  logic [31:0] ld_data_i,
  output logic        ld_ready_o,
  input  logic        ld_issue_i,
  input  logic [3:0]  ld_issue_rd_i,
  output logic [15:0] busy_o,
  output logic [3:0]  wp_addr_o,
  output logic [31:0] wp_data_o,
  output logic        wp_we1_o,
  output logic        wp_we2_o
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [SW-1:0]       starve_q, starve_d;
  logic                fifo_full, fifo_empty, fifo_push;
  logic                fifo_grant, ex_grant, ex_busy, starved;
  hs32_wbent           head, ld_ent;

  assign ld_ent    = {ld_rd_i, ld_data_i};
  assign fifo_push = ld_valid_i & ld_ready_o & ~reset;

  hs32_fifo #(
    .DEPTH(DEPTH),
    .T    (hs32_wbent)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (fifo_push),
    .wdata_i(ld_ent),
    .pop_i  (fifo_grant),
    .rdata_o(head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Grants are suppressed while reset is high so stale state never reaches the port.
  always_comb begin
    ex_busy    = busy_q[ex_rd_i];
    starved    = (starve_q == SW'(STARVE_LIMIT));
    fifo_grant = ~reset & ~fifo_empty &
                 (~ex_valid_i | fifo_full | starved | ex_busy);
    ex_grant   = ~reset & ex_valid_i & ~fifo_grant & ~ex_busy;
    ex_stall_o = ~reset & ex_valid_i & ~ex_grant;
    ld_ready_o = ~fifo_full | reset;

    wp_addr_o  = ex_rd_i;
    wp_data_o  = ex_data_i;
    wp_we1_o   = 1'b0;
    wp_we2_o   = 1'b0;
    if (fifo_grant) begin
      wp_addr_o = head.rd;
      wp_data_o = head.data;
      wp_we1_o  = 1'b1;
      wp_we2_o  = 1'b1;
    end else if (ex_grant) begin
      wp_we1_o  = ex_we1_i;
      wp_we2_o  = ex_we2_i;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_empty || fifo_grant) begin
      starve_d = '0;
    end else if (ex_grant && !starved) begin
      starve_d = starve_q + 1'b1;
    end

    // Issue is applied after the clear so a same-register set wins.
    busy_d = busy_q;
    if (fifo_grant) begin
      busy_d[head.rd] = 1'b0;
    end
    if (ld_issue_i) begin
      busy_d[ld_issue_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q   <= '0;
      starve_q <= '0;
    end else begin
      busy_q   <= busy_d;
      starve_q <= starve_d;
    end
  end

  assign busy_o = busy_q;

endmodule

// File: tb/tb_hs32_wbarb.sv
// Bench for hs32_wbarb: vector table for the execute path, hand sequences for
// load priority, starvation, full buffer, WAW hazard and mid-run reset.
module tb_hs32_wbarb;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid_i, ex_we1_i, ex_we2_i;
  logic [3:0]  ex_rd_i;
  logic [31:0] ex_data_i;
  logic        ex_stall_o;
  logic        ld_valid_i;
  logic [3:0]  ld_rd_i;
  logic [31:0] ld_data_i;
  logic        ld_ready_o;
  logic        ld_issue_i;
  logic [3:0]  ld_issue_rd_i;
  logic [15:0] busy_o;
  logic [3:0]  wp_addr_o;
  logic [31:0] wp_data_o;
  logic        wp_we1_o, wp_we2_o;

  int checks = 0;
  int errors = 0;

  // {addr, data, we1, we2}
  logic [37:0] exp_q[$];

  hs32_wbarb #(.STARVE_LIMIT(4), .DEPTH(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .ex_valid_i   (ex_valid_i),
    .ex_rd_i      (ex_rd_i),
    .ex_data_i    (ex_data_i),
    .ex_we1_i     (ex_we1_i),
    .ex_we2_i     (ex_we2_i),
    .ex_stall_o   (ex_stall_o),
    .ld_valid_i   (ld_valid_i),
    .ld_rd_i      (ld_rd_i),
    .ld_data_i    (ld_data_i),
    .ld_ready_o   (ld_ready_o),
    .ld_issue_i   (ld_issue_i),
    .ld_issue_rd_i(ld_issue_rd_i),
    .busy_o       (busy_o),
    .wp_addr_o    (wp_addr_o),
    .wp_data_o    (wp_data_o),
    .wp_we1_o     (wp_we1_o),
    .wp_we2_o     (wp_we2_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic idle();
    ex_valid_i    = 1'b0;
    ex_rd_i       = 4'd0;
    ex_data_i     = 32'd0;
    ex_we1_i      = 1'b0;
    ex_we2_i      = 1'b0;
    ld_valid_i    = 1'b0;
    ld_rd_i       = 4'd0;
    ld_data_i     = 32'd0;
    ld_issue_i    = 1'b0;
    ld_issue_rd_i = 4'd0;
  endtask

  task automatic drive_ex(input logic [3:0] rd, input logic [31:0] data);
    ex_valid_i = 1'b1;
    ex_rd_i    = rd;
    ex_data_i  = data;
    ex_we1_i   = 1'b1;
    ex_we2_i   = 1'b1;
  endtask

  task automatic drive_ld(input logic [3:0] rd, input logic [31:0] data);
    ld_valid_i = 1'b1;
    ld_rd_i    = rd;
    ld_data_i  = data;
  endtask

  task automatic expect_wr(input logic [3:0] addr, input logic [31:0] data,
                           input logic we1, input logic we2);
    exp_q.push_back({addr, data, we1, we2});
  endtask

  // Write-port scoreboard: every enabled write must match the oldest expectation.
  always @(negedge clk) begin
    if (wp_we1_o | wp_we2_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wp_unexpected actual addr=%0d data=0x%08h we=%b%b required no write",
                 wp_addr_o, wp_data_o, wp_we1_o, wp_we2_o);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        if ({wp_addr_o, wp_data_o, wp_we1_o, wp_we2_o} !== e) begin
          errors++;
          $display("FAIL wp_write actual addr=%0d data=0x%08h we=%b%b required addr=%0d data=0x%08h we=%b%b",
                   wp_addr_o, wp_data_o, wp_we1_o, wp_we2_o, e[37:34], e[33:2], e[1], e[0]);
        end
      end
    end
  end

  // Issuing a load to a register that is already outstanding is illegal stimulus.
  always @(posedge clk) begin
    if (!reset && ld_issue_i) begin
      checks++;
      if (busy_o[ld_issue_rd_i]) begin
        errors++;
        $display("FAIL issue_to_busy actual busy rd=%0d required not busy", ld_issue_rd_i);
      end
    end
  end

  typedef struct {
    logic        ex_valid;
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we1;
    logic        we2;
    logic        exp_stall;
    logic        exp_we1;
    logic        exp_we2;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 4'd3,  32'h1234_5678, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 4'd4,  32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 4'd15, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'd0,  32'h0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 4'd8,  $urandom,      1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b1, 4'd12, $urandom,      1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

    // Reset: outputs quiet even with an execute request pending.
    idle();
    reset = 1'b1;
    drive_ex(4'd3, 32'h1111_1111);
    settle();
    chk("rst_ld_ready", 32'(ld_ready_o), 32'd1);
    chk("rst_ex_stall", 32'(ex_stall_o), 32'd0);
    chk("rst_we", {30'd0, wp_we1_o, wp_we2_o}, 32'd0);
    tick();
    tick();
    chk("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b0;
    idle();
    settle();
    chk("post_rst_ld_ready", 32'(ld_ready_o), 32'd1);
    chk("post_rst_ex_stall", 32'(ex_stall_o), 32'd0);
    chk("post_rst_we", {30'd0, wp_we1_o, wp_we2_o}, 32'd0);
    chk("post_rst_busy", 32'(busy_o), 32'd0);
    tick();

    // Execute path with an empty buffer: zero-latency pass-through.
    for (int i = 0; i < 6; i++) begin
      idle();
      ex_valid_i = vecs[i].ex_valid;
      ex_rd_i    = vecs[i].rd;
      ex_data_i  = vecs[i].data;
      ex_we1_i   = vecs[i].we1;
      ex_we2_i   = vecs[i].we2;
      if (vecs[i].exp_we1 | vecs[i].exp_we2)
        expect_wr(vecs[i].rd, vecs[i].data, vecs[i].exp_we1, vecs[i].exp_we2);
      settle();
      chk($sformatf("vec%0d_stall", i), 32'(ex_stall_o), 32'(vecs[i].exp_stall));
      chk($sformatf("vec%0d_we", i), {30'd0, wp_we1_o, wp_we2_o},
          {30'd0, vecs[i].exp_we1, vecs[i].exp_we2});
      tick();
    end

    // Load-return priority and scoreboard clear.
    idle();
    ld_issue_i = 1'b1; ld_issue_rd_i = 4'd5;
    tick();
    idle();
    drive_ld(4'd5, 32'hAA55_AA55);
    settle();
    chk("ld_busy5_set", 32'(busy_o), 32'h0000_0020);
    chk("ld_ready", 32'(ld_ready_o), 32'd1);
    chk("ld_not_same_cycle", 32'(wp_we1_o), 32'd0);
    tick();
    idle();
    expect_wr(4'd5, 32'hAA55_AA55, 1'b1, 1'b1);
    settle();
    chk("ld_write_next", 32'(wp_we1_o), 32'd1);
    chk("ld_busy5_during", 32'(busy_o), 32'h0000_0020);
    tick();
    settle();
    chk("ld_busy5_clear", 32'(busy_o), 32'd0);
    tick();

    // Starvation: four execute grants, then the buffered load wins.
    idle();
    ld_issue_i = 1'b1; ld_issue_rd_i = 4'd2;
    tick();
    idle();
    drive_ld(4'd2, 32'h0BAD_0002);
    drive_ex(4'd9, 32'h9000_0000);
    expect_wr(4'd9, 32'h9000_0000, 1'b1, 1'b1);
    settle();
    chk("starve_acc_stall", 32'(ex_stall_o), 32'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      idle();
      drive_ex(4'd9, 32'h9000_0000 + 32'(i));
      expect_wr(4'd9, 32'h9000_0000 + 32'(i), 1'b1, 1'b1);
      settle();
      chk($sformatf("starve_ex%0d_stall", i), 32'(ex_stall_o), 32'd0);
      tick();
    end
    idle();
    drive_ex(4'd9, 32'h9000_0005);
    expect_wr(4'd2, 32'h0BAD_0002, 1'b1, 1'b1);
    settle();
    chk("starve_ld_stall", 32'(ex_stall_o), 32'd1);
    tick();
    expect_wr(4'd9, 32'h9000_0005, 1'b1, 1'b1);
    settle();
    chk("starve_resume_stall", 32'(ex_stall_o), 32'd0);
    chk("starve_busy_clear", 32'(busy_o), 32'd0);
    tick();

    // Full buffer under continuous execute; a third load waits and is not lost.
    idle();
    drive_ex(4'd1, 32'h1000_0001);
    drive_ld(4'd10, 32'hA000_0001);
    expect_wr(4'd1, 32'h1000_0001, 1'b1, 1'b1);
    settle();
    chk("full_c1_ready", 32'(ld_ready_o), 32'd1);
    tick();
    drive_ex(4'd1, 32'h1000_0002);
    drive_ld(4'd11, 32'hA000_0002);
    expect_wr(4'd1, 32'h1000_0002, 1'b1, 1'b1);
    settle();
    chk("full_c2_ready", 32'(ld_ready_o), 32'd1);
    chk("full_c2_stall", 32'(ex_stall_o), 32'd0);
    tick();
    drive_ex(4'd1, 32'h1000_0003);
    drive_ld(4'd12, 32'hA000_0003);
    expect_wr(4'd10, 32'hA000_0001, 1'b1, 1'b1);
    settle();
    chk("full_c3_ready", 32'(ld_ready_o), 32'd0);
    chk("full_c3_stall", 32'(ex_stall_o), 32'd1);
    tick();
    ex_valid_i = 1'b0;
    expect_wr(4'd11, 32'hA000_0002, 1'b1, 1'b1);
    settle();
    chk("full_c4_ready", 32'(ld_ready_o), 32'd1);
    tick();
    idle();
    expect_wr(4'd12, 32'hA000_0003, 1'b1, 1'b1);
    settle();
    chk("full_c5_we", 32'(wp_we1_o), 32'd1);
    tick();

    // WAW: execute to r7 waits for the outstanding load to r7.
    idle();
    ld_issue_i = 1'b1; ld_issue_rd_i = 4'd7;
    tick();
    idle();
    for (int i = 0; i < 2; i++) begin
      drive_ex(4'd7, 32'h7777_0001);
      settle();
      chk($sformatf("waw_wait%0d_stall", i), 32'(ex_stall_o), 32'd1);
      tick();
    end
    drive_ld(4'd7, 32'h7E7E_7E7E);
    settle();
    chk("waw_acc_stall", 32'(ex_stall_o), 32'd1);
    chk("waw_acc_ready", 32'(ld_ready_o), 32'd1);
    tick();
    ld_valid_i = 1'b0;
    expect_wr(4'd7, 32'h7E7E_7E7E, 1'b1, 1'b1);
    settle();
    chk("waw_ld_stall", 32'(ex_stall_o), 32'd1);
    chk("waw_ld_busy", 32'(busy_o), 32'h0000_0080);
    tick();
    expect_wr(4'd7, 32'h7777_0001, 1'b1, 1'b1);
    settle();
    chk("waw_ex_stall", 32'(ex_stall_o), 32'd0);
    chk("waw_busy_clear", 32'(busy_o), 32'd0);
    tick();

    // Reset mid-operation discards the buffered entry and the scoreboard.
    idle();
    ld_issue_i = 1'b1; ld_issue_rd_i = 4'd7;
    tick();
    idle();
    drive_ld(4'd4, 32'h4444_0004);
    settle();
    chk("mid_busy_before", 32'(busy_o), 32'h0000_0080);
    tick();
    idle();
    reset = 1'b1;
    settle();
    chk("mid_rst_we", {30'd0, wp_we1_o, wp_we2_o}, 32'd0);
    chk("mid_rst_ready", 32'(ld_ready_o), 32'd1);
    tick();
    reset = 1'b0;
    settle();
    chk("mid_post_busy", 32'(busy_o), 32'd0);
    chk("mid_post_ready", 32'(ld_ready_o), 32'd1);
    chk("mid_post_we", {30'd0, wp_we1_o, wp_we2_o}, 32'd0);
    tick();
    settle();
    chk("mid_post2_we", {30'd0, wp_we1_o, wp_we2_o}, 32'd0);
    tick();
    tick();

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
